sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO. Successor to the basic full/empty FIFO, adding:
- a fill-level count output;
- programmable almost_full and almost_empty thresholds;
- overflow and underflow error pulses;
- a build-time choice between registered-read mode and first-word-fall-through (FWFT) mode.

It sits between producer and consumer blocks on the same clock as the standard buffering element.

---
 rtl/sync_fifo_flags_pkg.sv | 18 +
 rtl/sync_fifo_flags_mem.sv | 26 ++
 rtl/sync_fifo_flags.sv | 108 ++++++++++
 tb/tb_sync_fifo_flags.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and helpers for the flagged synchronous FIFO.
package sync_fifo_flags_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Ceiling log2, used for pointer width (count is one bit wider)
   function automatic int fifo_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: contents are never cleared, reset only discards them logically
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost flags, error pulses
// and a build-time choice of registered or first-word-fall-through read.
module sync_fifo_flags
   import sync_fifo_flags_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = FIFO_MODE_STD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [fifo_clog2(DEPTH):0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = fifo_clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // Flags come from the count register only, so they lag the operation by one edge
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // FWFT shows the head combinationally and forces zero when nothing is queued
   assign data_out = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : mem_rdata) : dout_q;

   // Accept decisions, pointer/count next state, registered read data and error pulses
   always_comb begin
      rd_acc   = rd_en && !empty;
      // A write into a full FIFO is only legal when a read frees a slot this same edge
      wr_acc   = wr_en && (!full || rd_acc);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ovf_d    = wr_en && !wr_acc;
      udf_d    = rd_en && !rd_acc;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_rdata;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset; wr_en/rd_en have no effect in the reset cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench: registered-read and FWFT instances fed identical stimulus, checked
// against a queue-based model of the FIFO.
module tb_sync_fifo_flags;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] data_in;

   logic [7:0] dout_s, dout_f;
   logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
   logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
   logic [3:0] count_s, count_f;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [7:0] q[$];
   logic [7:0] exp_std;
   logic       exp_ovf, exp_udf;

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
      .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(udf_s));

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fw (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
      .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flags implied by a fill level: {full, empty, almost_full, almost_empty}
   function automatic logic [3:0] flags_for(input int n);
      return {n == 8, n == 0, n >= 6, n <= 1};
   endfunction

   function automatic logic [7:0] fw_head();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   // Drive one cycle, advance the model, and sample #1 after the edge
   task automatic do_cycle(input logic w, input logic [7:0] d, input logic r, input logic rs);
      logic rdacc, wracc;
      rst = rs; wr_en = w; rd_en = r; data_in = d;
      if (rs) begin
         q.delete();
         exp_std = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
      end else begin
         rdacc   = r && (q.size() > 0);
         wracc   = w && ((q.size() < 8) || rdacc);
         exp_ovf = w && !wracc;
         exp_udf = r && !rdacc;
         if (rdacc) exp_std = q.pop_front();
         if (wracc) q.push_back(d);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      do_cycle(1'b1, 8'hFF, 1'b1, 1'b1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tests++; if (count_s !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count_s); end
      tests++; if ({full_s, empty_s, af_s, ae_s} !== 4'b0101) begin fails++; $display("FAIL reset_flags_std got=%b exp=0101", {full_s, empty_s, af_s, ae_s}); end
      tests++; if ({full_f, empty_f, af_f, ae_f} !== 4'b0101) begin fails++; $display("FAIL reset_flags_fw got=%b exp=0101", {full_f, empty_f, af_f, ae_f}); end
      tests++; if (dout_s !== 8'h00 || dout_f !== 8'h00) begin fails++; $display("FAIL reset_dout got=%h/%h exp=00/00", dout_s, dout_f); end
      tests++; if ({ovf_s, udf_s, ovf_f, udf_f} !== 4'b0000) begin fails++; $display("FAIL reset_err got=%b exp=0000", {ovf_s, udf_s, ovf_f, udf_f}); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b1, 8'(i + 1), 1'b0, 1'b0);
         tests++; if (count_s !== 4'(i + 1) || count_f !== 4'(i + 1)) begin fails++; $display("FAIL fill_count got=%0d/%0d exp=%0d", count_s, count_f, i + 1); end
         tests++; if ({full_s, empty_s, af_s, ae_s} !== flags_for(i + 1)) begin fails++; $display("FAIL fill_flags got=%b exp=%b", {full_s, empty_s, af_s, ae_s}, flags_for(i + 1)); end
         tests++; if (dout_f !== 8'h01) begin fails++; $display("FAIL fill_fw_head got=%h exp=01", dout_f); end
      end
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         tests++; if (dout_s !== 8'(i + 1)) begin fails++; $display("FAIL drain_std got=%h exp=%h", dout_s, 8'(i + 1)); end
         tests++; if (dout_f !== ((i < 7) ? 8'(i + 2) : 8'h00)) begin fails++; $display("FAIL drain_fw got=%h exp=%h", dout_f, (i < 7) ? 8'(i + 2) : 8'h00); end
         tests++; if (count_s !== 4'(7 - i)) begin fails++; $display("FAIL drain_count got=%0d exp=%0d", count_s, 7 - i); end
      end
      tests++; if (empty_s !== 1'b1 || empty_f !== 1'b1) begin fails++; $display("FAIL drain_empty got=%b/%b exp=1/1", empty_s, empty_f); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      do_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      tests++; if (ovf_s !== 1'b1 || ovf_f !== 1'b1) begin fails++; $display("FAIL ovf_pulse got=%b/%b exp=1/1", ovf_s, ovf_f); end
      tests++; if (count_s !== 4'd8 || full_s !== 1'b1) begin fails++; $display("FAIL ovf_count got=%0d full=%b exp=8 full=1", count_s, full_s); end
      do_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      tests++; if (ovf_s !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf_s); end
      tests++; if (count_s !== 4'd8) begin fails++; $display("FAIL full_rw_count got=%0d exp=8", count_s); end
      tests++; if (dout_s !== 8'h10 || dout_f !== 8'h11) begin fails++; $display("FAIL full_rw_data got=%h/%h exp=10/11", dout_s, dout_f); end
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         tests++; if (dout_s !== exp_std) begin fails++; $display("FAIL ovf_drain got=%h exp=%h", dout_s, exp_std); end
      end
      tests++; if (dout_s !== 8'hAA) begin fails++; $display("FAIL ovf_last_aa got=%h exp=aa", dout_s); end
   endtask

   task automatic test_underflow();
      do_cycle(1'b1, 8'h55, 1'b1, 1'b0);
      tests++; if (udf_s !== 1'b1 || udf_f !== 1'b1) begin fails++; $display("FAIL udf_pulse got=%b/%b exp=1/1", udf_s, udf_f); end
      tests++; if (count_s !== 4'd1) begin fails++; $display("FAIL udf_count got=%0d exp=1", count_s); end
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      tests++; if (udf_s !== 1'b0) begin fails++; $display("FAIL udf_one_cycle got=%b exp=0", udf_s); end
      tests++; if (dout_s !== 8'h55) begin fails++; $display("FAIL udf_read got=%h exp=55", dout_s); end
   endtask

   task automatic test_fwft();
      do_cycle(1'b1, 8'h11, 1'b0, 1'b0);
      tests++; if (dout_f !== 8'h11) begin fails++; $display("FAIL fwft_first got=%h exp=11", dout_f); end
      do_cycle(1'b1, 8'h22, 1'b0, 1'b0);
      tests++; if (dout_f !== 8'h11) begin fails++; $display("FAIL fwft_hold got=%h exp=11", dout_f); end
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      tests++; if (dout_f !== 8'h22) begin fails++; $display("FAIL fwft_pop got=%h exp=22", dout_f); end
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      tests++; if (dout_f !== 8'h00 || empty_f !== 1'b1) begin fails++; $display("FAIL fwft_empty got=%h empty=%b exp=00 empty=1", dout_f, empty_f); end
      tests++; if (dout_s !== 8'h22) begin fails++; $display("FAIL std_after_fwft got=%h exp=22", dout_s); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      do_cycle(1'b1, 8'h99, 1'b0, 1'b1);
      tests++; if (count_s !== 4'd0 || empty_s !== 1'b1) begin fails++; $display("FAIL midrst_count got=%0d empty=%b exp=0 empty=1", count_s, empty_s); end
      tests++; if (dout_s !== 8'h00 || dout_f !== 8'h00) begin fails++; $display("FAIL midrst_dout got=%h/%h exp=00/00", dout_s, dout_f); end
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tests++; if (count_f !== 4'd0) begin fails++; $display("FAIL midrst_write_ignored got=%0d exp=0", count_f); end
   endtask

   // Random traffic with a slowly changing write/read bias so both ends get hit
   task automatic test_random();
      int wp, rp;
      for (int i = 0; i < 300; i++) begin
         wp = ((i / 40) % 2 == 0) ? 75 : 30;
         rp = 100 - wp;
         do_cycle($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp, 1'b0);
         tests++; if (count_s !== 4'(q.size()) || count_f !== 4'(q.size())) begin fails++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", i, count_s, count_f, q.size()); end
         tests++; if ({full_s, empty_s, af_s, ae_s} !== flags_for(q.size())) begin fails++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {full_s, empty_s, af_s, ae_s}, flags_for(q.size())); end
         tests++; if (dout_s !== exp_std) begin fails++; $display("FAIL rnd_std cyc=%0d got=%h exp=%h", i, dout_s, exp_std); end
         tests++; if (dout_f !== fw_head()) begin fails++; $display("FAIL rnd_fw cyc=%0d got=%h exp=%h", i, dout_f, fw_head()); end
         tests++; if ({ovf_s, udf_s, ovf_f, udf_f} !== {exp_ovf, exp_udf, exp_ovf, exp_udf}) begin fails++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, {ovf_s, udf_s, ovf_f, udf_f}, {exp_ovf, exp_udf, exp_ovf, exp_udf}); end
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
      exp_std = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_fwft();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
